freq_meas_sched: RTL and testbench

Time-multiplexed measurement scheduler that shares a single edge-counting window engine among `N_CH` asynchronous square-wave inputs. It arbitrates level requests from per-channel clients round-robin and selects the granted channel into the counter. It sequences a settle/count window and returns the pulse count through a valid/ready result port. It sits between the sensor front-ends and the per-channel LED/bucket decoders on the 48 MHz HSOSC clock domain.

---
 rtl/freq_meas_pkg.sv | 24 ++
 rtl/freq_meas_sched_edge_window_counter.sv | 57 +++++
 rtl/freq_meas_sched.sv | 163 ++++++++++++++++
 tb/tb_freq_meas_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared types, defaults and helpers for the frequency measurement scheduler
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    COUNT,
    REPORT
  } meas_state_t;

  localparam int DEF_CLK_HZ        = 48_000_000;
  localparam int DEF_N_CH          = 4;
  localparam int DEF_WINDOW_CYCLES = DEF_CLK_HZ / 200;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 14;
  localparam int DEF_TIMER_W       = 18;

  // Channel index width; never narrower than one bit.
  function automatic int CH_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freq_meas_sched_edge_window_counter.sv
// rtl/freq_meas_sched_edge_window_counter.sv - rising-edge detector with saturating pulse counter
module edge_window_counter #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clr,
  input  logic             arm,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             edge_det;

  // Edge detect, prev preload while armed or counting, saturating increment.
  always_comb begin
    edge_det = sig_in & ~prev_q;
    prev_d   = prev_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (arm || en) begin
      prev_d = sig_in;
    end
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en && edge_det) begin
      if (&count_q) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/freq_meas_sched.sv
// rtl/freq_meas_sched.sv - round-robin scheduler sharing one edge-counting window among channels
module freq_meas_sched
  import freq_meas_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TIMER_W       = DEF_TIMER_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sq_in,
  input  logic [N_CH-1:0]         meas_req,
  output logic [N_CH-1:0]         meas_ack,
  output logic                    busy,
  output logic [CH_W(N_CH)-1:0]   active_ch,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CH_W(N_CH)-1:0]   result_ch,
  output logic [CNT_W-1:0]        result_count,
  output logic                    result_ovf
);

  localparam int CW = CH_W(N_CH);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);

  // First requester after 'last', wrapping; returns {found, index}.
  function automatic logic [CW:0] rr_pick(input logic [N_CH-1:0] req, input logic [CW-1:0] last);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(last) + i) % N_CH;
      if (req[CW'(idx)]) begin
        res = {1'b1, CW'(idx)};
      end
    end
    return res;
  endfunction

  meas_state_t      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_CH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]    active_ch_q, active_ch_d;
  logic [CW-1:0]    last_ch_q, last_ch_d;
  logic [CW-1:0]    result_ch_q, result_ch_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic [N_CH-1:0]  meas_ack_q, meas_ack_d;
  logic [N_CH-1:0]  ack_mask;
  logic [CW:0]      pick;
  logic             cnt_clr, cnt_arm, cnt_en;

  // Sequencing of select/settle/count/report and the result handshake.
  always_comb begin
    sync1_d        = sq_in;
    sync2_d        = sync1_q;
    state_d        = state_q;
    timer_d        = timer_q;
    active_ch_d    = active_ch_q;
    last_ch_d      = last_ch_q;
    result_ch_d    = result_ch_q;
    result_valid_d = result_valid_q;
    meas_ack_d     = '0;
    cnt_clr        = 1'b0;
    cnt_arm        = 1'b0;
    cnt_en         = 1'b0;
    pick           = rr_pick(meas_req, last_ch_q);
    ack_mask       = '0;
    ack_mask[result_ch_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (|meas_req) state_d = SELECT;
      end
      SELECT: begin
        cnt_clr = 1'b1;
        timer_d = '0;
        if (pick[CW]) begin
          active_ch_d = pick[CW-1:0];
          state_d     = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        cnt_arm = 1'b1;
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = COUNT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        if (timer_q == WINDOW_LAST) begin
          state_d        = REPORT;
          result_valid_d = 1'b1;
          result_ch_d    = active_ch_q;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      REPORT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          meas_ack_d     = ack_mask;
          last_ch_d      = result_ch_q;
          state_d        = (|(meas_req & ~ack_mask)) ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      sync1_q        <= '0;
      sync2_q        <= '0;
      active_ch_q    <= '0;
      last_ch_q      <= CW'(N_CH - 1);
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      meas_ack_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      active_ch_q    <= active_ch_d;
      last_ch_q      <= last_ch_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      meas_ack_q     <= meas_ack_d;
    end
  end

  edge_window_counter #(.CNT_W(CNT_W)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sync2_q[active_ch_q]),
    .clr    (cnt_clr),
    .arm    (cnt_arm),
    .en     (cnt_en),
    .count  (result_count),
    .ovf    (result_ovf)
  );

  assign meas_ack     = meas_ack_q;
  assign busy         = busy_q;
  assign active_ch    = active_ch_q;
  assign result_valid = result_valid_q;
  assign result_ch    = result_ch_q;

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb/tb_freq_meas_sched.sv - directed self-checking bench for freq_meas_sched
module tb_freq_meas_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sq_in = '0;
  logic [3:0]  meas_req = '0;
  logic        result_ready = 1'b0;

  logic [3:0]  meas_ack;
  logic        busy;
  logic [1:0]  active_ch;
  logic        result_valid;
  logic [1:0]  result_ch;
  logic [13:0] result_count;
  logic        result_ovf;

  logic [3:0]  s_ack;
  logic        s_busy;
  logic [1:0]  s_active_ch;
  logic        s_valid;
  logic [1:0]  s_ch;
  logic [3:0]  s_count;
  logic        s_ovf;

  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          per_ch[4] = '{default: 0};
  logic [3:0]  lvl = '0;
  int          cyc = 0;
  int          ack_pulses = 0;

  freq_meas_sched #(.N_CH(4), .WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(14), .TIMER_W(18)) dut (
    .clk(clk), .reset(reset), .sq_in(sq_in), .meas_req(meas_req), .meas_ack(meas_ack),
    .busy(busy), .active_ch(active_ch), .result_valid(result_valid), .result_ready(result_ready),
    .result_ch(result_ch), .result_count(result_count), .result_ovf(result_ovf)
  );

  freq_meas_sched #(.N_CH(4), .WINDOW_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .TIMER_W(18)) dut_sat (
    .clk(clk), .reset(reset), .sq_in(sq_in), .meas_req(meas_req), .meas_ack(s_ack),
    .busy(s_busy), .active_ch(s_active_ch), .result_valid(s_valid), .result_ready(result_ready),
    .result_ch(s_ch), .result_count(s_count), .result_ovf(s_ovf)
  );

  always #5 clk = ~clk;

  // Square waves: period per_ch[c] cycles (rising edge once per period), or static lvl[c] when 0.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < 4; c++) begin
        sq_in[c] = (per_ch[c] == 0) ? lvl[c] : ((cyc % per_ch[c]) < (per_ch[c] / 2));
      end
    end
  end

  always @(negedge clk) ack_pulses += $countones(meas_ack);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check("valid_within_bound", result_valid, 1);
  endtask

  int          n;
  int          ack_base;
  logic        stable, no_ack, busy_all;
  logic [31:0] snap;
  int          exp_rr[5] = '{10, 20, 5, 25, 10};
  int          ch_rr[5]  = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_active_ch", active_ch, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ack", meas_ack, 0);
    check("rst_count", result_count, 0);
    check("rst_ovf", result_ovf, 0);
    check("rst_sat_busy", s_busy, 0);
    reset = 1'b0;
    tick(3);

    // Basic count on ch2, period 10 -> 10 edges, latency 106
    per_ch[2] = 10;
    meas_req = 4'b0100;
    wait_valid(n);
    check("basic_latency", n, 106);
    check("basic_ch", result_ch, 2);
    check("basic_count", result_count, 10);
    check("basic_ovf", result_ovf, 0);
    check("basic_busy", busy, 1);
    check("basic_active_ch", active_ch, 2);

    // Backpressure: 50 cycles with ready low and inputs toggling
    per_ch[2] = 3;
    per_ch[0] = 4;
    snap = {16'(result_count), 12'd0, result_ch, result_ovf, result_valid};
    ack_base = ack_pulses;
    stable = 1'b1;
    no_ack = 1'b1;
    busy_all = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if ({16'(result_count), 12'd0, result_ch, result_ovf, result_valid} !== snap) stable = 1'b0;
      if (meas_ack !== 4'b0000) no_ack = 1'b0;
      if (busy !== 1'b1) busy_all = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_ack", no_ack, 1);
    check("bp_busy", busy_all, 1);
    check("bp_ack_count", ack_pulses - ack_base, 0);
    result_ready = 1'b1;
    tick(1);
    check("bp_ack", meas_ack, 4'b0100);
    check("bp_valid_drop", result_valid, 0);
    meas_req = 4'b0000;
    tick(1);
    check("bp_ack_single", meas_ack, 0);
    check("bp_idle", busy, 0);

    // Reset in the middle of a COUNT window (timer = 50)
    per_ch[1] = 5;
    meas_req = 4'b0010;
    tick(56);
    check("mid_busy", busy, 1);
    check("mid_active_ch", active_ch, 1);
    check("mid_count_nonzero", (result_count != 0), 1);
    reset = 1'b1;
    meas_req = 4'b0000;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_active_ch", active_ch, 0);
    check("mid_rst_result_ch", result_ch, 0);
    check("mid_rst_count", result_count, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_ack", meas_ack, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post_rst_idle", busy, 0);

    // ch3 and ch0 together after reset: ch0 first, then round-robin over all four
    per_ch[0] = 10;
    per_ch[1] = 5;
    per_ch[2] = 20;
    per_ch[3] = 4;
    meas_req = 4'b1001;
    tick(2);
    check("rr_first_ch0", active_ch, 0);
    meas_req = 4'b1111;
    ack_base = ack_pulses;
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      check("rr_ch", result_ch, ch_rr[k]);
      check("rr_count", result_count, exp_rr[k]);
      tick(1);
      check("rr_ack", meas_ack, 32'(1 << ch_rr[k]));
      meas_req[ch_rr[k]] = 1'b0;
      if (k == 3) meas_req[0] = 1'b1;
    end
    tick(1);
    check("rr_ack_total", ack_pulses - ack_base, 5);

    // Switch glitch: ch0 static high, ch1 static low
    per_ch[0] = 0;
    per_ch[1] = 0;
    lvl[0] = 1'b1;
    lvl[1] = 1'b0;
    tick(5);
    meas_req = 4'b0010;
    wait_valid(n);
    check("glitch_ch1", result_ch, 1);
    check("glitch_ch1_count", result_count, 0);
    tick(1);
    meas_req = 4'b0001;
    wait_valid(n);
    check("glitch_ch0", result_ch, 0);
    check("glitch_ch0_count", result_count, 0);
    check("glitch_ch0_ovf", result_ovf, 0);
    tick(1);
    meas_req = 4'b0000;
    tick(2);

    // Saturation: ch3 period 4 -> 25 edges; 4-bit instance saturates at 15
    per_ch[3] = 4;
    meas_req = 4'b1000;
    wait_valid(n);
    check("sat_ch", result_ch, 3);
    check("sat_wide_count", result_count, 25);
    check("sat_wide_ovf", result_ovf, 0);
    check("sat_valid", s_valid, 1);
    check("sat_ch_narrow", s_ch, 3);
    check("sat_count", s_count, 15);
    check("sat_ovf", s_ovf, 1);
    check("sat_active_ch", s_active_ch, 3);
    tick(1);
    check("sat_ack", s_ack, 4'b1000);
    meas_req = 4'b0000;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
